// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl: set-associative L2 tag/MESI/true-LRU controller, one trace command per request
// Ports: clk_i/reset_i (sync, active-high); req_valid_i/req_ready_o/req_cmd_i/req_addr_i command handshake;
//   snoop_in_i other caches' answer to our bus READ; bus_*_o bus op pulse; snp_*_o our snoop result pulse;
//   l1_*_o L1 message pulse; done_o/err_o end-of-command pulses; hit/read/write_cnt_o access counters.
module l2_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 8,
    parameter int LINE_BYTES = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_cmd_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        snoop_in_i,
    output logic              bus_valid_o,
    output logic [1:0]        bus_op_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              snp_valid_o,
    output logic [1:0]        snp_result_o,
    output logic              l1_valid_o,
    output logic [1:0]        l1_msg_o,
    output logic [ADDR_W-1:0] l1_addr_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       read_cnt_o,
    output logic [31:0]       write_cnt_o
);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int A_W   = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
    localparam logic [1:0] R_HIT = 2'd0, R_HITM = 2'd1, R_NOHIT = 2'd2;
    typedef enum logic [1:0] {IDLE, LOOKUP, STEP, WIPE} state_t;
    typedef enum logic [2:0] {P_EVWB, P_EV, P_FILL, P_INV, P_SEND, P_SNP, P_SNP2, P_NOP} phase_t;
    state_t state_q, state_d;
    phase_t phase_q, phase_d, first, fill_first;
    logic [3:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [A_W-1:0]    way_q, hway, vic, vinv, vage;
    logic              hit_q, hit, inv;
    logic [1:0]        lst_q, hst, vst, st_new;
    logic [TAG_W-1:0]  vtag_q;
    logic [IDX_W-1:0]  wset_q, wset_d;
    logic [31:0]       hit_cnt_q, read_cnt_q, write_cnt_q;
    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [1:0]        mesi_q [SETS][WAYS];
    logic [A_W-1:0]    age_q  [SETS][WAYS];
    logic              st_we, tag_we, lru_we, rd, wr, snp;
    logic [A_W-1:0]    lru_old;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] line, vline;
    assign idx   = addr_q[OFF_W +: IDX_W];
    assign tag   = addr_q[ADDR_W-1 -: TAG_W];
    assign line  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign vline = {vtag_q, idx, {OFF_W{1'b0}}};
    assign rd    = cmd_q == 4'd0 || cmd_q == 4'd2;
    assign wr    = cmd_q == 4'd1;
    assign snp   = cmd_q >= 4'd3 && cmd_q <= 4'd6;
    assign req_ready_o = state_q == IDLE;
    assign hit_cnt_o   = hit_cnt_q;
    assign read_cnt_o  = read_cnt_q;
    assign write_cnt_o = write_cnt_q;
    // Descending scan so the lowest matching way wins for each search.
    always_comb begin
        hit  = 1'b0;
        hway = '0;
        inv  = 1'b0;
        vinv = '0;
        vage = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mesi_q[idx][w] != ST_I && tag_q[idx][w] == tag) begin
                hit  = 1'b1;
                hway = A_W'(w);
            end
            if (mesi_q[idx][w] == ST_I) begin
                inv  = 1'b1;
                vinv = A_W'(w);
            end
            if (age_q[idx][w] == A_W'(WAYS - 1)) vage = A_W'(w);
        end
        vic = inv ? vinv : vage;
        hst = mesi_q[idx][hway];
        vst = mesi_q[idx][vic];
        fill_first = vst == ST_M ? P_EVWB : vst != ST_I ? P_EV : P_FILL;
        first = rd ? (hit ? P_SEND : fill_first) :
                wr ? (hit ? (hst == ST_S ? P_INV : P_SEND) : fill_first) :
                snp ? P_SNP : P_NOP;
    end
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        wset_d       = wset_q;
        bus_valid_o  = 1'b0;
        bus_op_o     = 2'd0;
        bus_addr_o   = line;
        snp_valid_o  = 1'b0;
        snp_result_o = R_NOHIT;
        l1_valid_o   = 1'b0;
        l1_msg_o     = 2'd0;
        l1_addr_o    = line;
        done_o       = 1'b0;
        err_o        = 1'b0;
        st_we        = 1'b0;
        st_new       = ST_I;
        tag_we       = 1'b0;
        lru_we       = 1'b0;
        lru_old      = age_q[idx][way_q];
        case (state_q)
            IDLE: if (req_valid_i) state_d = LOOKUP;
            LOOKUP: begin
                state_d = cmd_q == 4'd8 ? WIPE : STEP;
                phase_d = first;
                wset_d  = '0;
            end
            WIPE: begin
                wset_d = wset_q + IDX_W'(1);
                if (wset_q == IDX_W'(SETS - 1)) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: case (phase_q)
                P_EVWB: begin
                    bus_valid_o = 1'b1;
                    bus_op_o    = 2'd1;
                    bus_addr_o  = vline;
                    l1_valid_o  = 1'b1;
                    l1_msg_o    = 2'd0;
                    l1_addr_o   = vline;
                    phase_d     = P_EV;
                end
                P_EV: begin
                    l1_valid_o = 1'b1;
                    l1_msg_o   = 2'd3;
                    l1_addr_o  = vline;
                    phase_d    = P_FILL;
                end
                P_FILL: begin
                    bus_valid_o = 1'b1;
                    bus_op_o    = wr ? 2'd3 : 2'd0;
                    st_we       = 1'b1;
                    st_new      = wr ? ST_M : snoop_in_i == R_NOHIT ? ST_E : ST_S;
                    tag_we      = 1'b1;
                    lru_we      = 1'b1;
                    lru_old     = A_W'(WAYS - 1);
                    phase_d     = P_SEND;
                end
                P_INV: begin
                    bus_valid_o = 1'b1;
                    bus_op_o    = 2'd2;
                    st_we       = 1'b1;
                    st_new      = ST_M;
                    phase_d     = P_SEND;
                end
                P_SEND: begin
                    l1_valid_o = 1'b1;
                    l1_msg_o   = 2'd1;
                    st_we      = wr;
                    st_new     = ST_M;
                    lru_we     = hit_q;
                    done_o     = 1'b1;
                    state_d    = IDLE;
                end
                P_SNP: begin
                    snp_valid_o  = 1'b1;
                    snp_result_o = !hit_q ? R_NOHIT : lst_q == ST_M ? R_HITM : R_HIT;
                    done_o       = 1'b1;
                    state_d      = IDLE;
                    // A modified line must be written back before it is shared or given up.
                    if (hit_q && lst_q == ST_M && (cmd_q == 4'd4 || cmd_q == 4'd6)) begin
                        bus_valid_o = 1'b1;
                        bus_op_o    = 2'd1;
                        l1_valid_o  = 1'b1;
                        l1_msg_o    = 2'd0;
                    end
                    if (hit_q && cmd_q == 4'd4 && lst_q != ST_S) begin
                        st_we  = 1'b1;
                        st_new = ST_S;
                    end
                    if (hit_q && ((cmd_q == 4'd3 && lst_q == ST_S) || (cmd_q == 4'd6 && lst_q != ST_M))) begin
                        l1_valid_o = 1'b1;
                        l1_msg_o   = 2'd2;
                        st_we      = 1'b1;
                        st_new     = ST_I;
                    end
                    if (hit_q && cmd_q == 4'd6 && lst_q == ST_M) begin
                        done_o  = 1'b0;
                        state_d = STEP;
                        phase_d = P_SNP2;
                    end
                end
                P_SNP2: begin
                    l1_valid_o = 1'b1;
                    l1_msg_o   = 2'd2;
                    st_we      = 1'b1;
                    st_new     = ST_I;
                    done_o     = 1'b1;
                    state_d    = IDLE;
                end
                default: begin
                    done_o  = 1'b1;
                    err_o   = cmd_q != 4'd9;
                    state_d = IDLE;
                end
            endcase
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            phase_q     <= P_NOP;
            cmd_q       <= '0;
            addr_q      <= '0;
            way_q       <= '0;
            hit_q       <= 1'b0;
            lst_q       <= ST_I;
            vtag_q      <= '0;
            wset_q      <= '0;
            hit_cnt_q   <= '0;
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    mesi_q[s][w] <= ST_I;
                    age_q[s][w]  <= A_W'(w);
                end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wset_q  <= wset_d;
            if (req_valid_i && req_ready_o) begin
                cmd_q  <= req_cmd_i;
                addr_q <= req_addr_i;
            end
            if (state_q == LOOKUP) begin
                way_q  <= hit ? hway : vic;
                hit_q  <= hit;
                lst_q  <= hit ? hst : vst;
                vtag_q <= tag_q[idx][vic];
            end
            if (st_we) mesi_q[idx][way_q] <= st_new;
            if (tag_we) tag_q[idx][way_q] <= tag;
            if (lru_we)
                for (int w = 0; w < WAYS; w++)
                    age_q[idx][w] <= A_W'(w) == way_q ? '0 :
                                     age_q[idx][w] < lru_old ? age_q[idx][w] + A_W'(1) : age_q[idx][w];
            if (state_q == WIPE)
                for (int w = 0; w < WAYS; w++) begin
                    mesi_q[wset_q][w] <= ST_I;
                    age_q[wset_q][w]  <= A_W'(w);
                end
            if (state_q == STEP && phase_q == P_SEND) begin
                hit_cnt_q   <= hit_cnt_q + 32'(hit_q);
                read_cnt_q  <= read_cnt_q + 32'(rd);
                write_cnt_q <= write_cnt_q + 32'(wr);
            end
            if (state_q == WIPE && wset_q == IDX_W'(SETS - 1)) begin
                hit_cnt_q   <= '0;
                read_cnt_q  <= '0;
                write_cnt_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// tb_l2_cache_ctrl: directed self-checking bench for l2_cache_ctrl (4 sets, 8 ways, 64-byte lines)
module tb_l2_cache_ctrl;
    localparam logic [3:0] DRD = 4'd0, DWR = 4'd1, IRD = 4'd2, SINV = 4'd3, SRD = 4'd4;
    localparam logic [3:0] SWR = 4'd5, SRFO = 4'd6, CLR = 4'd8, PRT = 4'd9;
    localparam logic [1:0] B_RD = 2'd0, B_WR = 2'd1, B_INV = 2'd2, B_RWIM = 2'd3;
    localparam logic [1:0] HIT = 2'd0, HITM = 2'd1, NOHIT = 2'd2;
    localparam logic [1:0] GET = 2'd0, SEND = 2'd1, INVL = 2'd2, EVICT = 2'd3;
    logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_ready;
    logic [3:0]  req_cmd = 4'd0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  snoop_in = NOHIT;
    logic        bus_valid, snp_valid, l1_valid, done, err;
    logic [1:0]  bus_op, snp_result, l1_msg;
    logic [31:0] bus_addr, l1_addr, hit_cnt, read_cnt, write_cnt;
    int          checks = 0, errors = 0, lat, nbus, nl1, nsnp;
    logic [1:0]  sres;
    logic        errs;
    logic [41:0] bev [4];
    logic [41:0] lev [4];
    always #5 clk = ~clk;
    l2_cache_ctrl #(.ADDR_W(32), .SETS(4), .WAYS(8), .LINE_BYTES(64)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_cmd_i(req_cmd), .req_addr_i(req_addr), .snoop_in_i(snoop_in),
        .bus_valid_o(bus_valid), .bus_op_o(bus_op), .bus_addr_o(bus_addr),
        .snp_valid_o(snp_valid), .snp_result_o(snp_result),
        .l1_valid_o(l1_valid), .l1_msg_o(l1_msg), .l1_addr_o(l1_addr),
        .done_o(done), .err_o(err),
        .hit_cnt_o(hit_cnt), .read_cnt_o(read_cnt), .write_cnt_o(write_cnt)
    );
    function automatic logic [41:0] ev(input int cy, input logic [1:0] op, input logic [31:0] a);
        return {8'(cy), op, a};
    endfunction
    task automatic ck(input string t, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", t, o, e);
        end
    endtask
    // Issues one command from a negedge and logs every pulse by cycle offset from acceptance.
    task automatic run(input logic [3:0] c, input logic [31:0] a, input logic [1:0] s);
        nbus = 0;
        nl1  = 0;
        nsnp = 0;
        lat  = 0;
        errs = 1'b0;
        sres = 2'd3;
        for (int i = 0; i < 4; i++) begin
            bev[i] = '1;
            lev[i] = '1;
        end
        ck("ready_before_cmd", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_cmd   = c;
        req_addr  = a;
        snoop_in  = s;
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (bus_valid && nbus < 4) begin
                bev[nbus] = {8'(n), bus_op, bus_addr};
                nbus++;
            end
            if (l1_valid && nl1 < 4) begin
                lev[nl1] = {8'(n), l1_msg, l1_addr};
                nl1++;
            end
            if (snp_valid) begin
                nsnp++;
                sres = snp_result;
            end
            if (done) begin
                lat  = n;
                errs = err;
                break;
            end
            @(negedge clk);
        end
        ck("done_timeout", 64'(lat == 0), 64'(0));
        @(negedge clk);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ck("rst_ready", 64'(req_ready), 64'(1));
        ck("rst_cnts", {hit_cnt, read_cnt | write_cnt}, 64'(0));
        ck("rst_pulses", 64'({bus_valid, snp_valid, l1_valid, done, err}), 64'(0));
        run(DRD, 32'h1000, NOHIT);
        ck("drd_miss_lat", 64'(lat), 64'(3));
        ck("drd_miss_nbus", 64'(nbus), 64'(1));
        ck("drd_miss_read", 64'(bev[0]), 64'(ev(2, B_RD, 32'h1000)));
        ck("drd_miss_send", 64'(lev[0]), 64'(ev(3, SEND, 32'h1000)));
        ck("drd_miss_cnt", {hit_cnt, read_cnt}, {32'd0, 32'd1});
        run(DRD, 32'h1000, NOHIT);
        ck("drd_hit_lat", 64'(lat), 64'(2));
        ck("drd_hit_nbus", 64'(nbus), 64'(0));
        ck("drd_hit_send", 64'(lev[0]), 64'(ev(2, SEND, 32'h1000)));
        ck("drd_hit_cnt", {hit_cnt, read_cnt}, {32'd1, 32'd2});
        run(DWR, 32'h1000, NOHIT);
        ck("dwr_e_lat", 64'(lat), 64'(2));
        ck("dwr_e_nbus", 64'(nbus), 64'(0));
        ck("dwr_e_send", 64'(lev[0]), 64'(ev(2, SEND, 32'h1000)));
        ck("dwr_e_cnt", {hit_cnt, write_cnt}, {32'd2, 32'd1});
        run(SWR, 32'h1000, NOHIT);
        ck("swr_m", {32'(nsnp), 30'd0, sres}, {32'd1, 30'd0, HITM});
        ck("swr_m_quiet", 64'(nbus + nl1), 64'(0));
        run(SRD, 32'h1000, NOHIT);
        ck("srd_m_res", 64'(sres), 64'(HITM));
        ck("srd_m_write", 64'(bev[0]), 64'(ev(2, B_WR, 32'h1000)));
        ck("srd_m_get", 64'(lev[0]), 64'(ev(2, GET, 32'h1000)));
        ck("srd_m_lat", 64'(lat), 64'(2));
        run(DWR, 32'h1000, NOHIT);
        ck("dwr_s_lat", 64'(lat), 64'(3));
        ck("dwr_s_inv", 64'(bev[0]), 64'(ev(2, B_INV, 32'h1000)));
        ck("dwr_s_send", 64'(lev[0]), 64'(ev(3, SEND, 32'h1000)));
        ck("dwr_s_cnt", {hit_cnt, write_cnt}, {32'd3, 32'd2});
        run(SRFO, 32'h1000, NOHIT);
        ck("rfo_m_lat", 64'(lat), 64'(3));
        ck("rfo_m_res", 64'(sres), 64'(HITM));
        ck("rfo_m_write", 64'(bev[0]), 64'(ev(2, B_WR, 32'h1000)));
        ck("rfo_m_get", 64'(lev[0]), 64'(ev(2, GET, 32'h1000)));
        ck("rfo_m_invl", 64'(lev[1]), 64'(ev(3, INVL, 32'h1000)));
        run(SRFO, 32'h1000, NOHIT);
        ck("rfo_miss", {32'(lat), 30'd0, sres}, {32'd2, 30'd0, NOHIT});
        ck("rfo_miss_quiet", 64'(nbus + nl1), 64'(0));
        run(IRD, 32'h1040, HIT);
        ck("ird_miss_read", 64'(bev[0]), 64'(ev(2, B_RD, 32'h1040)));
        ck("ird_cnt", {hit_cnt, read_cnt}, {32'd3, 32'd3});
        run(SWR, 32'h1040, NOHIT);
        ck("swr_s", 64'(sres), 64'(HIT));
        run(SINV, 32'h1040, NOHIT);
        ck("sinv_s_res", 64'(sres), 64'(HIT));
        ck("sinv_s_invl", 64'(lev[0]), 64'(ev(2, INVL, 32'h1040)));
        run(SWR, 32'h1040, NOHIT);
        ck("sinv_left_i", 64'(sres), 64'(NOHIT));
        run(4'd7, 32'h0, NOHIT);
        ck("bad_cmd", {32'(lat), 31'd0, errs}, {32'd2, 32'd1});
        run(PRT, 32'h0, NOHIT);
        ck("print", {32'(lat), 31'd0, errs}, {32'd2, 32'd0});
        run(CLR, 32'h0, NOHIT);
        ck("clear_lat", 64'(lat), 64'(5));
        ck("clear_cnts", {hit_cnt, read_cnt | write_cnt}, 64'(0));
        for (int t = 0; t < 8; t++) run(DRD, 32'(t) << 8, NOHIT);
        ck("fill8_lat", 64'(lat), 64'(3));
        run(DRD, 32'h800, NOHIT);
        ck("evict_lat", 64'(lat), 64'(4));
        ck("evict_evl", 64'(lev[0]), 64'(ev(2, EVICT, 32'h0)));
        ck("evict_read", 64'(bev[0]), 64'(ev(3, B_RD, 32'h800)));
        ck("evict_send", 64'(lev[1]), 64'(ev(4, SEND, 32'h800)));
        ck("evict_cnt", {hit_cnt, read_cnt}, {32'd0, 32'd9});
        run(CLR, 32'h0, NOHIT);
        run(DWR, 32'h0, NOHIT);
        ck("dwr_miss_rwim", 64'(bev[0]), 64'(ev(2, B_RWIM, 32'h0)));
        ck("dwr_miss_send", 64'(lev[0]), 64'(ev(3, SEND, 32'h0)));
        for (int t = 1; t < 8; t++) run(DRD, 32'(t) << 8, NOHIT);
        run(DRD, 32'h800, NOHIT);
        ck("evm_lat", 64'(lat), 64'(5));
        ck("evm_write", 64'(bev[0]), 64'(ev(2, B_WR, 32'h0)));
        ck("evm_get", 64'(lev[0]), 64'(ev(2, GET, 32'h0)));
        ck("evm_evl", 64'(lev[1]), 64'(ev(3, EVICT, 32'h0)));
        ck("evm_read", 64'(bev[1]), 64'(ev(4, B_RD, 32'h800)));
        ck("evm_send", 64'(lev[2]), 64'(ev(5, SEND, 32'h800)));
        // Tag 1 is now oldest, so a write miss to 0x900 starts by evicting 0x100.
        req_valid = 1'b1;
        req_cmd   = DWR;
        req_addr  = 32'h900;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        ck("abort_evl", {30'd0, l1_valid, l1_msg, l1_addr}, {30'd0, 1'b1, EVICT, 32'h100});
        reset = 1'b1;
        @(negedge clk);
        ck("abort_rst_quiet", 64'({bus_valid, snp_valid, l1_valid, done}), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        ck("abort_ready", 64'(req_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            ck("abort_quiet", 64'({bus_valid, snp_valid, l1_valid, done}), 64'(0));
            @(negedge clk);
        end
        run(DRD, 32'h900, NOHIT);
        ck("abort_miss_lat", 64'(lat), 64'(3));
        ck("abort_miss_read", 64'(bev[0]), 64'(ev(2, B_RD, 32'h900)));
        ck("abort_cnt", {hit_cnt, read_cnt}, {32'd0, 32'd1});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
